// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   CLKDIV_CNT_W   default counter / half-period width
//   CLKDIV_DEF_HP  default half-period loaded at reset
//   ch_idx_w()     width of a channel index for a given channel count
package clkdiv_pkg;

    localparam int unsigned CLKDIV_CNT_W  = 32;
    localparam int unsigned CLKDIV_DEF_HP = 25000000;

    // A single channel still needs a 1-bit index port.
    function automatic int unsigned ch_idx_w(input int unsigned nch);
        if (nch <= 1) begin
            return 1;
        end
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active half-period, shadow half-period,
// pending flag, registered clkout and tick.
// Optional macro CLKDIV_PHASE_SYNC_EN adds the sync input.
// Ports:
//   clkin   clock (posedge)
//   clr     asynchronous active-high reset
//   en      run enable; 0 freezes counter and clkout
//   sync    (CLKDIV_PHASE_SYNC_EN only) restart phase, apply shadow now
//   wr      write strobe already decoded for this channel
//   wr_hp   new half-period value
//   clkout  divided clock
//   tick    one-cycle pulse coincident with each clkout toggle
//   pend    shadow value awaits application
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W  = CLKDIV_CNT_W,
    parameter logic [CNT_W-1:0] DEF_HP = CNT_W'(CLKDIV_DEF_HP)
) (
    input  logic             clkin,
    input  logic             clr,
    input  logic             en,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_hp,
    output logic             clkout,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             do_sync;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign do_sync = sync;
`else
    assign do_sync = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        hp_d   = hp_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;

        if (do_sync) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            hp_d   = sh_q;
            pend_d = 1'b0;
        end else if (en) begin
            if (cnt_q == hp_q) begin
                // Terminal count: the only point where hp may change, so the
                // half-period in progress always completes with its old value.
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                hp_d   = sh_q;
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A write coinciding with application lands in the shadow after the
        // old shadow has been taken, so pend stays set for the next boundary.
        if (wr) begin
            sh_d   = wr_hp;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            cnt_q  <= '0;
            hp_q   <= DEF_HP;
            sh_q   <= DEF_HP;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clkout = clk_q;
    assign tick   = tick_q;
    assign pend   = pend_q;

endmodule

// File: rtl/clkdiv_multi.sv
// NCH-channel runtime-programmable clock divider. Each channel toggles a
// 50%-duty clkout every (half-period + 1) clkin cycles; divisors are written
// through a channel-addressed port and applied at the next terminal count.
// Optional macro CLKDIV_PHASE_SYNC_EN adds the sync input that realigns all
// channels and applies pending divisors at once.
// Ports:
//   clkin   clock (posedge)
//   clr     asynchronous active-high reset
//   en      per-channel run enable
//   sync    (CLKDIV_PHASE_SYNC_EN only) phase-align all channels
//   wr      divisor write strobe
//   wr_ch   target channel; indices >= NCH are ignored
//   wr_hp   new half-period value
//   clkout  divided clock per channel
//   tick    per-channel toggle pulse
//   pend    per-channel pending-divisor flag
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned      NCH    = 2,
    parameter int unsigned      CNT_W  = CLKDIV_CNT_W,
    parameter logic [CNT_W-1:0] DEF_HP = CNT_W'(CLKDIV_DEF_HP)
) (
    input  logic                     clkin,
    input  logic                     clr,
    input  logic [NCH-1:0]           en,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                     sync,
`endif
    input  logic                     wr,
    input  logic [ch_idx_w(NCH)-1:0] wr_ch,
    input  logic [CNT_W-1:0]         wr_hp,
    output logic [NCH-1:0]           clkout,
    output logic [NCH-1:0]           tick,
    output logic [NCH-1:0]           pend
);

    localparam int unsigned CH_W = ch_idx_w(NCH);

    logic [NCH-1:0] wr_sel;

    // One-hot write decode; an out-of-range index matches no channel.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_sel[i] = wr && (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clkdiv_chan #(
            .CNT_W  (CNT_W),
            .DEF_HP (DEF_HP)
        ) u_chan (
            .clkin  (clkin),
            .clr    (clr),
            .en     (en[g]),
`ifdef CLKDIV_PHASE_SYNC_EN
            .sync   (sync),
`endif
            .wr     (wr_sel[g]),
            .wr_hp  (wr_hp),
            .clkout (clkout[g]),
            .tick   (tick[g]),
            .pend   (pend[g])
        );
    end

endmodule
